// File: rtl/gpu_mem_pkg.sv
// Shared memory-subsystem definitions for the SRAM port arbiter.
package gpu_mem_pkg;
  localparam int NUM_MEM_PORTS = 4;
  localparam int PORT_DISPLAY  = 0;
  localparam int SRAM_ADDR_W   = 24;
  localparam int SRAM_DATA_W   = 32;
  localparam int PORT_IDX_W    = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_MEM_PORTS-1:0] port_onehot(input logic [PORT_IDX_W-1:0] p);
    port_onehot    = '0;
    port_onehot[p] = 1'b1;
  endfunction
endpackage

// File: rtl/sram_rr_picker.sv
// Round-robin pick among general ports 1-3, searching from the port after rr_last.
module sram_rr_picker
  import gpu_mem_pkg::*;
(
  input  logic [3:1]            req,
  input  logic [PORT_IDX_W-1:0] rr_last,
  output logic                  valid,
  output logic [PORT_IDX_W-1:0] pick
);

  always_comb begin
    valid = |req;
    pick  = 2'd1;
    case (rr_last)
      2'd1:    pick = req[2] ? 2'd2 : (req[3] ? 2'd3 : 2'd1);
      2'd2:    pick = req[3] ? 2'd3 : (req[1] ? 2'd1 : 2'd2);
      default: pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd3);
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Four-port SRAM arbiter: display port with bounded priority, ports 1-3 round-robin,
// one transaction outstanding at a time.
module sram_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int DISP_MAX_CONSEC = 8
) (
  input  logic                                 clk_sram,
  input  logic                                 rst_sram,
  input  logic [NUM_MEM_PORTS-1:0]             req_i,
  input  logic [NUM_MEM_PORTS-1:0]             we_i,
  input  logic [NUM_MEM_PORTS*SRAM_ADDR_W-1:0] addr_i,
  input  logic [NUM_MEM_PORTS*SRAM_DATA_W-1:0] wdata_i,
  output logic [NUM_MEM_PORTS-1:0]             ack_o,
  output logic [SRAM_DATA_W-1:0]               rdata_o,
  output logic [NUM_MEM_PORTS-1:0]             ready_o,
  output logic                                 sram_req,
  output logic                                 sram_we,
  output logic [SRAM_ADDR_W-1:0]               sram_addr,
  output logic [SRAM_DATA_W-1:0]               sram_wdata,
  input  logic [SRAM_DATA_W-1:0]               sram_rdata,
  input  logic                                 sram_ack,
  input  logic                                 sram_ready
);

  localparam int STREAK_W = $clog2(DISP_MAX_CONSEC + 1) < 1 ? 1 : $clog2(DISP_MAX_CONSEC + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DISP_MAX_CONSEC);

  arb_state_t                                  r_state;
  logic [PORT_IDX_W-1:0]                       r_grant;
  logic [PORT_IDX_W-1:0]                       r_rr_last;
  logic [STREAK_W-1:0]                         r_streak;

  logic [NUM_MEM_PORTS-1:0][SRAM_ADDR_W-1:0]   w_addr;
  logic [NUM_MEM_PORTS-1:0][SRAM_DATA_W-1:0]   w_wdata;
  logic                                        w_rr_valid;
  logic [PORT_IDX_W-1:0]                       w_rr_pick;
  logic                                        w_disp_sel;
  logic [PORT_IDX_W-1:0]                       w_sel;
  logic                                        w_grant;

  assign w_addr  = addr_i;
  assign w_wdata = wdata_i;
  assign ready_o = {NUM_MEM_PORTS{sram_ready}};

  sram_rr_picker u_rr (
    .req     (req_i[3:1]),
    .rr_last (r_rr_last),
    .valid   (w_rr_valid),
    .pick    (w_rr_pick)
  );

  // Display wins until its streak saturates, but only while someone else is waiting.
  assign w_disp_sel = req_i[PORT_DISPLAY] &&
                      ((r_streak < STREAK_MAX) || (req_i[3:1] == 3'b000));
  assign w_sel      = w_disp_sel ? PORT_IDX_W'(PORT_DISPLAY) : w_rr_pick;
  assign w_grant    = sram_ready && (w_disp_sel || w_rr_valid);

  always_ff @(posedge clk_sram) begin
    if (rst_sram) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_rr_last  <= 2'd3;
      r_streak   <= '0;
      sram_req   <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      ack_o      <= '0;
      rdata_o    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          ack_o <= '0;
          if (w_grant) begin
            r_grant    <= w_sel;
            sram_req   <= 1'b1;
            sram_we    <= we_i[w_sel];
            sram_addr  <= w_addr[w_sel];
            sram_wdata <= w_wdata[w_sel];
            r_state    <= ARB_ISSUE;
            if (w_disp_sel) begin
              if (r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
            end else begin
              r_streak  <= '0;
              r_rr_last <= w_rr_pick;
            end
          end
        end
        ARB_ISSUE: begin
          if (sram_ack) begin
            sram_req <= 1'b0;
            rdata_o  <= sram_rdata;
            ack_o    <= port_onehot(r_grant);
            r_state  <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          ack_o   <= '0;
          r_state <= ARB_IDLE;
        end
        default: begin
          ack_o    <= '0;
          sram_req <= 1'b0;
          r_state  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sram_arbiter;
  localparam int DMAX = 8;

  logic          clk_sram = 1'b0;
  logic          rst_sram;
  logic [3:0]    req_i, we_i;
  logic [95:0]   addr_i;
  logic [127:0]  wdata_i;
  logic [3:0]    ack_o, ready_o;
  logic [31:0]   rdata_o;
  logic          sram_req, sram_we;
  logic [23:0]   sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic          sram_ack, sram_ready;

  sram_arbiter #(.DISP_MAX_CONSEC(DMAX)) dut (
    .clk_sram(clk_sram), .rst_sram(rst_sram), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .ready_o(ready_o), .sram_req(sram_req), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ack(sram_ack), .sram_ready(sram_ready)
  );

  initial forever #5 clk_sram = ~clk_sram;

  int n_checks = 0;
  int n_errs   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is either absent, waiting for the SRAM, or completing.
  int          m_phase, m_streak, m_rrl;
  bit          m_req, m_we;
  logic [23:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_ack;
  int          m_grant;

  task automatic model_step();
    int g;
    if (rst_sram) begin
      m_phase = 0; m_streak = 0; m_rrl = 3; m_grant = 0;
      m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_ack = '0; m_rdata = '0;
      return;
    end
    if (m_phase == 0) begin
      m_ack = '0;
      if (sram_ready && req_i != 4'b0) begin
        g = -1;
        if (req_i[0] && (m_streak < DMAX || req_i[3:1] == 3'b0)) g = 0;
        else
          for (int k = 1; k <= 3; k++) begin
            int p;
            p = (m_rrl + k - 1) % 3 + 1;
            if (g < 0 && req_i[p]) g = p;
          end
        if (g == 0) m_streak = (m_streak + 1 > DMAX) ? DMAX : m_streak + 1;
        else begin m_streak = 0; m_rrl = g; end
        m_grant = g;
        m_req   = 1;
        m_we    = we_i[g];
        m_addr  = addr_i[g*24 +: 24];
        m_wdata = wdata_i[g*32 +: 32];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (sram_ack) begin
        m_req   = 0;
        m_rdata = sram_rdata;
        m_ack   = 4'b0001 << m_grant;
        m_phase = 2;
      end
    end else begin
      m_ack   = '0;
      m_phase = 0;
    end
  endtask

  initial forever begin
    @(posedge clk_sram);
    model_step();
  end

  initial forever begin
    @(negedge clk_sram);
    if (cmp_en) begin
      chk("cyc_sram_req",   64'(sram_req),   64'(m_req));
      chk("cyc_sram_we",    64'(sram_we),    64'(m_we));
      chk("cyc_sram_addr",  64'(sram_addr),  64'(m_addr));
      chk("cyc_sram_wdata", 64'(sram_wdata), 64'(m_wdata));
      chk("cyc_ack_o",      64'(ack_o),      64'(m_ack));
      chk("cyc_rdata_o",    64'(rdata_o),    64'(m_rdata));
    end
  end

  task automatic tick();
    @(posedge clk_sram);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    sram_ack = 0; sram_rdata = '0; sram_ready = 1;
  endtask

  task automatic do_reset();
    rst_sram = 1;
    idle_inputs();
    tick(); tick();
    rst_sram = 0;
  endtask

  int grants[$];

  // Responder acks in the first issue cycle; grants are recorded from ack_o.
  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      for (int p = 0; p < 4; p++) if (ack_o[p]) grants.push_back(p);
      sram_ack   = sram_req;
      sram_rdata = $urandom;
    end
  endtask

  initial begin
    rst_sram = 1;
    idle_inputs();
    tick();
    cmp_en = 1;
    do_reset();

    // Reset state
    chk("rst_sram_req", 64'(sram_req), 64'h0);
    chk("rst_ack_o",    64'(ack_o),    64'h0);
    chk("rst_rdata_o",  64'(rdata_o),  64'h0);
    chk("rst_addr",     64'(sram_addr), 64'h0);
    chk("ready_hi",     64'(ready_o),  64'hF);
    sram_ready = 0; #1;
    chk("ready_lo",     64'(ready_o),  64'h0);
    sram_ready = 1;

    // Single read on port 2
    req_i = 4'b0100; addr_i[2*24 +: 24] = 24'h000123;
    tick();
    chk("rd_req",  64'(sram_req),  64'h1);
    chk("rd_addr", 64'(sram_addr), 64'h000123);
    chk("rd_we",   64'(sram_we),   64'h0);
    sram_ack = 1; sram_rdata = 32'hDEADBEEF; req_i = '0;
    tick();
    chk("rd_ack",   64'(ack_o),   64'h4);
    chk("rd_rdata", 64'(rdata_o), 64'hDEADBEEF);
    chk("rd_req_drop", 64'(sram_req), 64'h0);
    sram_ack = 0;
    tick();
    chk("rd_ack_gone", 64'(ack_o),   64'h0);
    chk("rd_rdata_hold", 64'(rdata_o), 64'hDEADBEEF);

    // Round-robin among ports 1-3
    do_reset();
    grants.delete();
    req_i = 4'b1110;
    run_auto(20);
    req_i = '0; run_auto(4);
    chk("rr_count_ge6", 64'(grants.size() >= 6), 64'h1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % 3 + 1));

    // Display streak cap against port 1
    do_reset();
    grants.delete();
    req_i = 4'b0011;
    run_auto(56);
    req_i = '0; run_auto(4);
    chk("disp_count_ge18", 64'(grants.size() >= 18), 64'h1);
    for (int i = 0; i < 18 && i < grants.size(); i++)
      chk($sformatf("disp_grant%0d", i), 64'(grants[i]), (i % 9 < 8) ? 64'h0 : 64'h1);

    // Not ready: nothing granted until sram_ready rises
    do_reset();
    sram_ready = 0; req_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("notrdy_req", 64'(sram_req), 64'h0);
    end
    sram_ready = 1;
    tick();
    chk("rdy_grant", 64'(sram_req), 64'h1);
    req_i = '0; sram_ack = 1;
    tick();
    chk("rdy_ack", 64'(ack_o), 64'h1);
    sram_ack = 0;
    tick();

    // Reset while issuing, then a late sram_ack
    do_reset();
    req_i = 4'b0010; addr_i[1*24 +: 24] = 24'h00BEEF; sram_rdata = 32'hCAFEF00D;
    tick();
    chk("abort_req", 64'(sram_req), 64'h1);
    rst_sram = 1; req_i = '0;
    tick();
    chk("abort_req_clr", 64'(sram_req), 64'h0);
    rst_sram = 0; sram_ack = 1;
    tick();
    chk("abort_no_ack", 64'(ack_o), 64'h0);
    sram_ack = 0;
    tick();
    chk("abort_no_ack2", 64'(ack_o),     64'h0);
    chk("abort_rdata",   64'(rdata_o),   64'h0);
    chk("abort_addr",    64'(sram_addr), 64'h0);
    chk("abort_req2",    64'(sram_req),  64'h0);

    // Port 3 write with a delayed ack
    do_reset();
    req_i = 4'b1000; we_i = 4'b1000;
    wdata_i[3*32 +: 32] = 32'h12345678; addr_i[3*24 +: 24] = 24'hABCDEF;
    tick();
    chk("wr_we",    64'(sram_we),    64'h1);
    chk("wr_wdata", 64'(sram_wdata), 64'h12345678);
    chk("wr_addr",  64'(sram_addr),  64'hABCDEF);
    req_i = '0; we_i = '0;
    tick();
    chk("wr_hold_req",   64'(sram_req),   64'h1);
    chk("wr_hold_wdata", 64'(sram_wdata), 64'h12345678);
    sram_ack = 1;
    tick();
    chk("wr_ack", 64'(ack_o), 64'h8);
    sram_ack = 0;
    tick();
    chk("wr_ack_gone", 64'(ack_o), 64'h0);

    // Randomized traffic, including spurious acks and occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_sram   = ($urandom_range(199) == 0);
      req_i      = {($urandom_range(9) < 5), ($urandom_range(9) < 5),
                    ($urandom_range(9) < 5), ($urandom_range(9) < 9)};
      we_i       = 4'($urandom);
      addr_i     = {$urandom, $urandom, $urandom};
      wdata_i    = {$urandom, $urandom, $urandom, $urandom};
      sram_ready = ($urandom_range(99) < 85);
      sram_ack   = ($urandom_range(1) == 1);
      sram_rdata = $urandom;
      tick();
    end
    rst_sram = 0;
    idle_inputs();
    tick(); tick(); tick(); tick();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
